// File: rtl/regfile_mp_if.sv
// Bundle of read, write and bulk-clear signals between decode/writeback and regfile_mp.
// The master drives addresses, write data and clear requests; the slave returns read data and clear status.
interface regfile_mp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hardwired zero register and a one-entry-per-cycle bulk clear.
// Reads are registered (1 cycle); writes are dropped while clearing. REGFILE_BYPASS_EN forwards same-edge writes to reads.
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31
) (
    input  logic        clock,
    input  logic        reset_n,
    regfile_mp_if.slave bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam bit                ZERO_EN  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ZERO_REG[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q  [NUM_RD];
    logic [DATA_W-1:0] rd_d  [NUM_RD];
    logic [ADDR_W-1:0] ra    [NUM_RD];
    logic              wr_ok;
    logic              sweep;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (a == ZERO_IDX);
    endfunction

    assign sweep = (state_q == CLEAR);
    assign wr_ok = bus.wr_en && (state_q == IDLE) && !is_zero(bus.wr_addr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clr_req) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Termination on the last index, not on wrap, so done lands on the final sweep edge.
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
            if (sweep) mem_q[idx_q] <= '0;
        end
    end

    for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_lane
        assign ra[gp]                                 = bus.rd_addr[gp*ADDR_W +: ADDR_W];
        assign bus.rd_data[gp*DATA_W +: DATA_W]        = rd_q[gp];
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_d[p] = mem_q[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (bus.wr_addr == ra[p])) rd_d[p] = bus.wr_data;
            if (sweep && (idx_q == ra[p]))       rd_d[p] = '0;
`endif
            if (is_zero(ra[p])) rd_d[p] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_RD; p++) rd_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) rd_q[p] <= rd_d[p];
        end
    end

    assign bus.clr_busy = busy_q;
    assign bus.clr_done = done_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default 32x64 two-port instance and a 8x32 four-port instance without zero register.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [63:0] DV = 64'hDEADBEEF_00000005;

    logic clock;
    logic reset_n;

    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) b0 ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) b1 ();

    regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(31)) u0 (
        .clock(clock), .reset_n(reset_n), .bus(b0));
    regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(8)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(b1));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    typedef struct {
        int          dut;
        int          lane;
        logic [63:0] exp;
        int          tag;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] lane_val(input int dut, input int lane);
        if (dut == 0) return b0.rd_data[lane*64 +: 64];
        return {32'h0, b1.rd_data[lane*32 +: 32]};
    endfunction

    function automatic logic [31:0] v1(input int i);
        return 32'hC0DE0000 + 32'(i * 17);
    endfunction

    task automatic expect_rd(input int dut, input int lane, input logic [63:0] e, input int tag);
        sb_t r;
        r.dut = dut; r.lane = lane; r.exp = e; r.tag = tag;
        sb.push_back(r);
    endtask

    task automatic tick();
        sb_t r;
        @(posedge clock);
        #1;
        while (sb.size() != 0) begin
            r = sb.pop_front();
            chk($sformatf("rd dut%0d lane%0d tag%0d", r.dut, r.lane, r.tag),
                lane_val(r.dut, r.lane), r.exp);
        end
    endtask

    task automatic rd1(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3);
        b1.rd_addr = {a3, a2, a1, a0};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        int   bcnt, dcnt, done_j, bad;

        vt[0] = '{1'b1, 5'd5,  DV,        5'd5,  5'd0,  BYP ? DV : 64'h0,        64'h0};
        vt[1] = '{1'b0, 5'd0,  64'h0,     5'd5,  5'd5,  DV,                      DV};
        vt[2] = '{1'b1, 5'd31, 64'h1234,  5'd31, 5'd5,  64'h0,                   DV};
        vt[3] = '{1'b0, 5'd0,  64'h0,     5'd31, 5'd31, 64'h0,                   64'h0};
        vt[4] = '{1'b1, 5'd7,  64'h77,    5'd7,  5'd5,  BYP ? 64'h77 : 64'h0,    DV};
        vt[5] = '{1'b1, 5'd7,  64'h78,    5'd7,  5'd7,  BYP ? 64'h78 : 64'h77,   BYP ? 64'h78 : 64'h77};
        vt[6] = '{1'b0, 5'd0,  64'h0,     5'd7,  5'd0,  64'h78,                  64'h0};
        vt[7] = '{1'b1, 5'd0,  64'h1,     5'd31, 5'd0,  64'h0,                   BYP ? 64'h1 : 64'h0};

        reset_n = 1'b1;
        b0.rd_addr = '0; b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0; b0.clr_req = 1'b0;
        b1.rd_addr = '0; b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0; b1.clr_req = 1'b0;
        #2 reset_n = 1'b0;
        #10;
        chk("reset busy0", {63'h0, b0.clr_busy}, 64'h0);
        chk("reset done0", {63'h0, b0.clr_done}, 64'h0);
        chk("reset busy1", {63'h0, b1.clr_busy}, 64'h0);
        chk("reset done1", {63'h0, b1.clr_done}, 64'h0);
        for (int l = 0; l < 2; l++) chk($sformatf("reset dut0 lane%0d", l), lane_val(0, l), 64'h0);
        for (int l = 0; l < 4; l++) chk($sformatf("reset dut1 lane%0d", l), lane_val(1, l), 64'h0);
        reset_n = 1'b1;

        // Every index reads zero after reset, including the zero register.
        for (int i = 0; i < 32; i++) begin
            b0.rd_addr = {5'(31 - i), 5'(i)};
            expect_rd(0, 0, 64'h0, 100 + i);
            expect_rd(0, 1, 64'h0, 100 + i);
            tick();
        end

        for (int v = 0; v < 8; v++) begin
            b0.wr_en = vt[v].we; b0.wr_addr = vt[v].wa; b0.wr_data = vt[v].wd;
            b0.rd_addr = {vt[v].ra1, vt[v].ra0};
            expect_rd(0, 0, vt[v].e0, 200 + v);
            expect_rd(0, 1, vt[v].e1, 200 + v);
            tick();
        end
        b0.wr_en = 1'b0;
        b0.rd_addr = {5'd0, 5'd7};
        expect_rd(0, 0, 64'h78, 210);
        expect_rd(0, 1, 64'h1, 210);
        tick();

        for (int i = 0; i < 32; i++) begin
            b0.wr_en = 1'b1; b0.wr_addr = 5'(i); b0.wr_data = 64'(i + 1);
            tick();
        end
        b0.wr_en = 1'b0;

        // Bulk clear with a dropped write to index 3 and an ignored re-request mid-sweep.
        b0.clr_req = 1'b1;
        b0.rd_addr = {5'd3, 5'd20};
        expect_rd(0, 0, 64'd21, 300);
        expect_rd(0, 1, 64'd4, 300);
        tick();
        bcnt = b0.clr_busy ? 1 : 0;
        dcnt = 0;
        done_j = -1;
        for (int j = 0; j < 40; j++) begin
            b0.clr_req = (j == 10);
            b0.wr_en = (j == 4); b0.wr_addr = 5'd3; b0.wr_data = 64'hFF;
            expect_rd(0, 0, (j < 20 || (!BYP && j == 20)) ? 64'd21 : 64'h0, 310 + j);
            expect_rd(0, 1, (j < 3 || (!BYP && j == 3)) ? 64'd4 : 64'h0, 310 + j);
            tick();
            if (b0.clr_busy) bcnt++;
            if (b0.clr_done) begin
                dcnt++;
                done_j = j;
            end
        end
        b0.wr_en = 1'b0;
        chk("sweep busy cycles", 64'(bcnt), 64'd32);
        chk("sweep done pulses", 64'(dcnt), 64'd1);
        chk("sweep done position", 64'(done_j), 64'd31);
        for (int i = 0; i < 32; i++) begin
            b0.rd_addr = {5'(31 - i), 5'(i)};
            expect_rd(0, 0, 64'h0, 400 + i);
            expect_rd(0, 1, 64'h0, 400 + i);
            tick();
        end

        // Reset ten cycles into a sweep; unswept entries must still come back zero.
        for (int i = 20; i < 31; i++) begin
            b0.wr_en = 1'b1; b0.wr_addr = 5'(i); b0.wr_data = 64'(256 + i);
            tick();
        end
        b0.wr_en = 1'b0;
        b0.rd_addr = {5'd25, 5'd25};
        b0.clr_req = 1'b1;
        tick();
        b0.clr_req = 1'b0;
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (b0.clr_done) bad++;
        end
        chk("pre-reset lane0 holds data", lane_val(0, 0), 64'd281);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset busy", {63'h0, b0.clr_busy}, 64'h0);
        chk("async reset done", {63'h0, b0.clr_done}, 64'h0);
        chk("async reset lane0", lane_val(0, 0), 64'h0);
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            b0.rd_addr = {5'(31 - i), 5'(i)};
            expect_rd(0, 0, 64'h0, 500 + i);
            expect_rd(0, 1, 64'h0, 500 + i);
            tick();
            if (b0.clr_done || b0.clr_busy) bad++;
        end
        chk("no done or busy after reset abort", 64'(bad), 64'h0);

        // Small configuration: no zero register, four lanes, eight-cycle clear.
        for (int i = 0; i < 8; i++) begin
            b1.wr_en = 1'b1; b1.wr_addr = 3'(i); b1.wr_data = v1(i);
            tick();
        end
        b1.wr_en = 1'b0;
        rd1(3'd7, 3'd0, 3'd3, 3'd5);
        expect_rd(1, 0, 64'(v1(7)), 600); expect_rd(1, 1, 64'(v1(0)), 600);
        expect_rd(1, 2, 64'(v1(3)), 600); expect_rd(1, 3, 64'(v1(5)), 600);
        tick();
        rd1(3'd1, 3'd6, 3'd2, 3'd7);
        expect_rd(1, 0, 64'(v1(1)), 601); expect_rd(1, 1, 64'(v1(6)), 601);
        expect_rd(1, 2, 64'(v1(2)), 601); expect_rd(1, 3, 64'(v1(7)), 601);
        tick();
        rd1(3'd4, 3'd4, 3'd7, 3'd0);
        expect_rd(1, 0, 64'(v1(4)), 602); expect_rd(1, 1, 64'(v1(4)), 602);
        expect_rd(1, 2, 64'(v1(7)), 602); expect_rd(1, 3, 64'(v1(0)), 602);
        tick();

        b1.clr_req = 1'b1;
        tick();
        b1.clr_req = 1'b0;
        bcnt = b1.clr_busy ? 1 : 0;
        dcnt = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (b1.clr_busy) bcnt++;
            if (b1.clr_done) dcnt++;
        end
        chk("small sweep busy cycles", 64'(bcnt), 64'd8);
        chk("small sweep done pulses", 64'(dcnt), 64'd1);
        rd1(3'd7, 3'd6, 3'd5, 3'd4);
        for (int l = 0; l < 4; l++) expect_rd(1, l, 64'h0, 610);
        tick();
        rd1(3'd3, 3'd2, 3'd1, 3'd0);
        for (int l = 0; l < 4; l++) expect_rd(1, l, 64'h0, 611);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
